// File: rtl/hw_accel_dma_stream_ctrl_pkg.sv
// Shared types and size helpers for the hw_accel DMA stream controller.
// Frame/transfer sizes are module parameters, so they are derived through functions.
package hw_accel_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        GAP,
        FLUSH
    } state_e;

    function automatic int frame_words(input int width, input int height);
        return width * height;
    endfunction

    function automatic int n_xfer(input int width, input int height, input int xfer_len);
        return (width * height) / xfer_len;
    endfunction

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hw_accel_dma_stream_ctrl_if.sv
// Handshake bundle between the controller, the pixel source/sink and the DMA streams.
// master is the controller side; slave is the surrounding frame-buffer/accelerator side.
interface hw_accel_dma_stream_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      src_valid;
    logic                      src_ready;
    logic [DATA_WIDTH-1:0]     src_data;
    logic                      dma_rvalid;
    logic                      dma_rready;
    logic [DATA_WIDTH/8-1:0]   dma_rkeep;
    logic [DATA_WIDTH-1:0]     dma_rdata;
    logic                      dma_wvalid;
    logic                      dma_wready;
    logic                      dma_wlast;
    logic [DATA_WIDTH-1:0]     dma_wdata;
    logic                      snk_valid;
    logic                      snk_ready;
    logic [DATA_WIDTH-1:0]     snk_data;

    modport master (
        input  src_valid, src_data, dma_rready, dma_wvalid, dma_wlast, dma_wdata, snk_ready,
        output src_ready, dma_rvalid, dma_rkeep, dma_rdata, dma_wready, snk_valid, snk_data
    );

    modport slave (
        output src_valid, src_data, dma_rready, dma_wvalid, dma_wlast, dma_wdata, snk_ready,
        input  src_ready, dma_rvalid, dma_rkeep, dma_rdata, dma_wready, snk_valid, snk_data
    );
endinterface

// File: rtl/hw_accel_dma_stream_ctrl_skid_fifo.sv
// Two-entry valid/ready FIFO; a push is visible on out_valid the following cycle.
// Simultaneous push and pop are allowed and leave the occupancy unchanged.
module hw_accel_skid_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: rtl/hw_accel_dma_stream_ctrl.sv
// DMA-side frame sequencer: feeds the read stream, drains the write stream,
// checks wlast framing and arms the accelerator once per write transfer.
module hw_accel_dma_stream_ctrl
    import hw_accel_dma_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int FRAME_WIDTH         = 640,
    parameter int FRAME_HEIGHT        = 480,
    parameter int DMA_TRANSFER_LENGTH = 1920,
    parameter int INIT_LOW_CYCLES     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    hw_accel_dma_stream_ctrl_if.master bus,
    output logic                    hw_accel_dma_init_done,
    output logic                    err_wlast_early,
    output logic                    err_wlast_missing,
    output logic [31:0]             rd_words_count,
    output logic [31:0]             wr_words_count
);
    localparam int FRAME_WORDS = frame_words(FRAME_WIDTH, FRAME_HEIGHT);
    localparam int N_XFER      = n_xfer(FRAME_WIDTH, FRAME_HEIGHT, DMA_TRANSFER_LENGTH);
    localparam int XFER_W      = cnt_width(DMA_TRANSFER_LENGTH - 1);
    localparam int GAP_W       = cnt_width(INIT_LOW_CYCLES - 1);
    localparam int DONE_W      = cnt_width(N_XFER);
    localparam int ISSUE_W     = cnt_width(FRAME_WORDS);

    if (FRAME_WORDS % DMA_TRANSFER_LENGTH != 0) begin : g_bad_xfer_len
        $error("FRAME_WIDTH*FRAME_HEIGHT must be a multiple of DMA_TRANSFER_LENGTH");
    end
    if (INIT_LOW_CYCLES < 3) begin : g_bad_init_low
        $error("INIT_LOW_CYCLES must be at least 3");
    end

    state_e               state, state_nxt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [XFER_W-1:0]    xfer_cnt;
    logic [DONE_W-1:0]    xfers_done;
    logic [ISSUE_W-1:0]   src_issued;
    logic                 src_gate, src_fifo_ready, snk_fifo_ready;
    logic                 src_beat, rd_beat, wr_beat, last_slot, close_beat, start_frame;

    assign busy                   = (state != IDLE);
    assign hw_accel_dma_init_done = (state == ARM);
    assign bus.dma_rkeep          = '1;

    // The source stops accepting once a whole frame has entered the controller.
    assign src_gate      = busy && (src_issued < ISSUE_W'(FRAME_WORDS));
    assign bus.src_ready = src_gate && src_fifo_ready;
    assign bus.dma_wready = busy && snk_fifo_ready;

    assign src_beat    = bus.src_valid && bus.src_ready;
    assign rd_beat     = bus.dma_rvalid && bus.dma_rready;
    assign wr_beat     = bus.dma_wvalid && bus.dma_wready;
    assign last_slot   = (xfer_cnt == XFER_W'(DMA_TRANSFER_LENGTH - 1));
    assign close_beat  = wr_beat && last_slot;
    assign start_frame = (state == IDLE) && start;

    hw_accel_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_src_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.src_valid && src_gate),
        .in_ready  (src_fifo_ready),
        .in_data   (bus.src_data),
        .out_valid (bus.dma_rvalid),
        .out_ready (bus.dma_rready),
        .out_data  (bus.dma_rdata)
    );

    hw_accel_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_snk_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.dma_wvalid && busy),
        .in_ready  (snk_fifo_ready),
        .in_data   (bus.dma_wdata),
        .out_valid (bus.snk_valid),
        .out_ready (bus.snk_ready),
        .out_data  (bus.snk_data)
    );

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ARM;
            ARM:   if (close_beat) state_nxt = GAP;
            GAP: begin
                if (gap_cnt == GAP_W'(INIT_LOW_CYCLES - 1))
                    state_nxt = (xfers_done < DONE_W'(N_XFER)) ? ARM : FLUSH;
            end
            FLUSH: if (!bus.dma_rvalid && !bus.snk_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            frame_done        <= 1'b0;
            gap_cnt           <= '0;
            xfer_cnt          <= '0;
            xfers_done        <= '0;
            src_issued        <= '0;
            rd_words_count    <= '0;
            wr_words_count    <= '0;
            err_wlast_early   <= 1'b0;
            err_wlast_missing <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == FLUSH) && (state_nxt == IDLE);
            gap_cnt    <= (state == GAP && state_nxt == GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (start_frame) begin
                xfer_cnt          <= '0;
                xfers_done        <= '0;
                src_issued        <= '0;
                rd_words_count    <= '0;
                wr_words_count    <= '0;
                err_wlast_early   <= 1'b0;
                err_wlast_missing <= 1'b0;
            end else begin
                if (src_beat) src_issued <= src_issued + ISSUE_W'(1);
                if (rd_beat)  rd_words_count <= rd_words_count + 32'd1;
                if (wr_beat) begin
                    wr_words_count <= wr_words_count + 32'd1;
                    xfer_cnt       <= last_slot ? '0 : xfer_cnt + XFER_W'(1);
                    if (!last_slot && bus.dma_wlast) err_wlast_early   <= 1'b1;
                    if (last_slot && !bus.dma_wlast) err_wlast_missing <= 1'b1;
                end
                if (state == ARM && close_beat) xfers_done <= xfers_done + DONE_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hw_accel_dma_stream_ctrl.sv
// Frame-level bench: scenario table plus a reset-mid-frame sequence, with a queue
// scoreboard for word order and an accelerator model that returns read words as writes.
module tb_hw_accel_dma_stream_ctrl;
    localparam int DW  = 32;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int L   = 16;
    localparam int ILC = 4;
    localparam int FW  = W * H;
    localparam int NX  = FW / L;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, frame_done, init_done, err_early, err_missing;
    logic [31:0] rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    hw_accel_dma_stream_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    hw_accel_dma_stream_ctrl #(
        .DATA_WIDTH          (DW),
        .FRAME_WIDTH         (W),
        .FRAME_HEIGHT        (H),
        .DMA_TRANSFER_LENGTH (L),
        .INIT_LOW_CYCLES     (ILC)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .start                  (start),
        .busy                   (busy),
        .frame_done             (frame_done),
        .bus                    (bus),
        .hw_accel_dma_init_done (init_done),
        .err_wlast_early        (err_early),
        .err_wlast_missing      (err_missing),
        .rd_words_count         (rd_cnt),
        .wr_words_count         (wr_cnt)
    );

    typedef struct {
        int rready_mode;   // 0: always 1, 1: 1-0-1 pattern, 2: random
        bit src_rand;      // random src_valid/data and random snk_ready
        int stall_start;   // first cycle of snk_ready low window (-1: none)
        int stall_len;
        int miss_beat;     // global write beat whose wlast is dropped (-1: none)
        int early_beat;    // global write beat given a spurious wlast (-1: none)
        bit start_in_arm;
        bit exp_early;
        bit exp_missing;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.src_valid  = 1'b0;
        bus.src_data   = '0;
        bus.dma_rready = 1'b0;
        bus.dma_wvalid = 1'b0;
        bus.dma_wlast  = 1'b0;
        bus.dma_wdata  = '0;
        bus.snk_ready  = 1'b1;
        start          = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input int rst_at);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] acc_q[$];
        logic [DW-1:0] cur_data, prev_rdata;
        int  accepted, g, arm_beats, inits, low_len, fd_pulses, tail;
        bit  prev_init, prev_stall, start_sent, rb, sb, wb, kb;
        accepted = 0; g = 0; arm_beats = 0; inits = 0; low_len = 0;
        fd_pulses = 0; tail = 0;
        prev_init = 1'b0; prev_stall = 1'b0; start_sent = 1'b0;
        prev_rdata = '0;
        cur_data = v.src_rand ? DW'($urandom) : '0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && tail < 3; cyc++) begin
            // Arm edges and low-phase length seen by the accelerator.
            if (init_done && !prev_init) begin
                inits++;
                arm_beats = 0;
                if (inits > 1) check("init_low_cycles", low_len, ILC);
            end
            low_len   = init_done ? 0 : low_len + 1;
            prev_init = init_done;
            if (frame_done) fd_pulses++;
            if (fd_pulses > 0) tail++;

            if (rst_at >= 0 && wr_cnt == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("rst_mid_busy", busy, 0);
                check("rst_mid_init_done", init_done, 0);
                check("rst_mid_rd_cnt", rd_cnt, 0);
                check("rst_mid_wr_cnt", wr_cnt, 0);
                check("rst_mid_src_fifo_empty", bus.dma_rvalid, 0);
                check("rst_mid_snk_fifo_empty", bus.snk_valid, 0);
                check("rst_mid_no_frame_done", frame_done, 0);
                rst = 1'b0;
                idle_inputs();
                return;
            end

            bus.src_valid = v.src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.src_data  = cur_data;
            case (v.rready_mode)
                0:       bus.dma_rready = 1'b1;
                1:       bus.dma_rready = (cyc % 3) != 1;
                default: bus.dma_rready = 1'($urandom_range(0, 1));
            endcase
            if (acc_q.size() > 0 && init_done && arm_beats < L) begin
                bus.dma_wvalid = 1'b1;
                bus.dma_wdata  = acc_q[0];
                bus.dma_wlast  = ((g % L) == L - 1);
                if (g == v.miss_beat)  bus.dma_wlast = 1'b0;
                if (g == v.early_beat) bus.dma_wlast = 1'b1;
            end else begin
                bus.dma_wvalid = 1'b0;
                bus.dma_wdata  = '0;
                bus.dma_wlast  = 1'b0;
            end
            if (v.stall_start >= 0 && cyc >= v.stall_start && cyc < v.stall_start + v.stall_len)
                bus.snk_ready = 1'b0;
            else
                bus.snk_ready = v.src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            start = v.start_in_arm && init_done && !start_sent;
            if (start) start_sent = 1'b1;

            #1;
            if (prev_stall) begin
                check("rvalid_held", bus.dma_rvalid, 1);
                check("rdata_held", bus.dma_rdata, prev_rdata);
            end
            prev_stall = bus.dma_rvalid && !bus.dma_rready;
            prev_rdata = bus.dma_rdata;

            sb = bus.src_valid && bus.src_ready;
            rb = bus.dma_rvalid && bus.dma_rready;
            wb = bus.dma_wvalid && bus.dma_wready;
            kb = bus.snk_valid && bus.snk_ready;
            if (sb) begin
                exp_q.push_back(bus.src_data);
                accepted++;
                cur_data = v.src_rand ? DW'($urandom) : DW'(accepted);
            end
            if (rb) acc_q.push_back(bus.dma_rdata);
            if (wb) begin
                void'(acc_q.pop_front());
                g++;
                arm_beats++;
            end
            if (kb) begin
                check("snk_word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("snk_data_order", bus.snk_data, exp_q.pop_front());
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("frame_done_pulses", fd_pulses, 1);
        check("src_words_accepted", accepted, FW);
        check("rd_words_count", rd_cnt, FW);
        check("wr_words_count", wr_cnt, FW);
        check("words_left_undelivered", exp_q.size(), 0);
        check("init_done_rises", inits, NX);
        check("err_wlast_early", err_early, v.exp_early);
        check("err_wlast_missing", err_missing, v.exp_missing);
        check("busy_after_frame", busy, 0);
        idle_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, -1, 0,  -1, -1, 1'b0, 1'b0, 1'b0};  // nominal
        vecs[1] = '{1, 1'b0,  5, 10, -1, -1, 1'b0, 1'b0, 1'b0};  // backpressure
        vecs[2] = '{0, 1'b0, -1, 0,  15, -1, 1'b0, 1'b0, 1'b1};  // wlast missing
        vecs[3] = '{0, 1'b0, -1, 0,  -1,  7, 1'b0, 1'b1, 1'b0};  // wlast early
        vecs[4] = '{0, 1'b0, -1, 0,  -1, -1, 1'b1, 1'b0, 1'b0};  // start during ARM
        vecs[5] = '{2, 1'b1, -1, 0,  -1, -1, 1'b0, 1'b0, 1'b0};  // random traffic
        vecs[6] = '{2, 1'b1, 12, 6,  -1, 20, 1'b0, 1'b1, 1'b0};  // random + early wlast

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_init_done", init_done, 0);
        check("reset_errors", {err_early, err_missing}, 0);
        check("reset_counts", {rd_cnt, wr_cnt}, 0);
        check("reset_fifo_valids", {bus.dma_rvalid, bus.snk_valid}, 0);
        check("reset_ready", {bus.src_ready, bus.dma_wready}, 0);
        check("reset_rkeep", bus.dma_rkeep, 4'hF);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], -1);

        run_frame(vecs[0], 20);
        repeat (2) @(negedge clk);
        run_frame(vecs[0], -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
